regfile_scoreboard: RTL

Parametrised multi-port integer register file with a per-register busy scoreboard for the in-order pipeline. It provides NUM_RD combinational read ports, two writeback ports, and a single-destination issue port that marks registers pending until writeback. It sits between decode/issue, which reads operands, checks hazards and reserves destinations, and the writeback stage, which supplies results and releases reservations.

---
 rtl/regfile_scoreboard.sv | 80 ++++++++
 1 files changed

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with per-register busy scoreboard for in-order issue.
// Define REGFILE_FWD_EN to forward same-cycle writeback data and busy release onto the read ports.
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wb0_en,
    input  logic [ADDR_W-1:0]        wb0_addr,
    input  logic [DATA_W-1:0]        wb0_data,
    input  logic                     wb1_en,
    input  logic [ADDR_W-1:0]        wb1_addr,
    input  logic [DATA_W-1:0]        wb1_data,
    input  logic                     issue_valid,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic                     issue_ready,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_count
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy, busy_nxt;
    logic [ADDR_W:0]   cnt_nxt;
    logic              wb0_hit, wb1_hit, issue_fire;

    assign wb0_hit    = wb0_en && (wb0_addr != '0);
    assign wb1_hit    = wb1_en && (wb1_addr != '0);
    // A destination still pending may be re-reserved only if its writeback lands this cycle.
    assign issue_ready = !flush && ((issue_addr == '0) || !busy[issue_addr] ||
                         (wb0_en && wb0_addr == issue_addr) || (wb1_en && wb1_addr == issue_addr));
    assign issue_fire = issue_valid && issue_ready;

    always_comb begin
        busy_nxt = busy;
        if (wb0_hit) busy_nxt[wb0_addr] = 1'b0;
        if (wb1_hit) busy_nxt[wb1_addr] = 1'b0;
        if (issue_fire) busy_nxt[issue_addr] = 1'b1;
        if (flush) busy_nxt = '0;
        busy_nxt[0] = 1'b0;
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            if (wb0_hit) mem[wb0_addr] <= wb0_data;
            if (wb1_hit) mem[wb1_addr] <= wb1_data;
            busy       <= busy_nxt;
            busy_count <= cnt_nxt;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        assign ra = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_FWD_EN
        assign rd_data[k*DATA_W +: DATA_W] = (ra == '0) ? '0 :
                                             (wb1_en && wb1_addr == ra) ? wb1_data :
                                             (wb0_en && wb0_addr == ra) ? wb0_data : mem[ra];
        assign rd_busy[k] = busy[ra] && !((wb0_en && wb0_addr == ra) || (wb1_en && wb1_addr == ra));
`else
        assign rd_data[k*DATA_W +: DATA_W] = (ra == '0) ? '0 : mem[ra];
        assign rd_busy[k] = busy[ra];
`endif
    end
endmodule
